// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM states, default word width and
// the mode-0 / MSB-first framing constants used with SPI_driver.
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  localparam int SPI_DATA_W = 8;

  localparam bit SPI_MSB_FIRST = 1'b1;
  localparam bit SPI_CPOL      = 1'b0;
  localparam bit SPI_CPHA      = 1'b0;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one SPI pin, plus rise/fall
// detection against one extra delayed copy of the synced value.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_peripheral.sv
// Mode-0, MSB-first SPI target with oversampled pins, a one-word
// receive strobe and a single-entry valid/ready transmit buffer.
module spi_peripheral
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SPI_CLK,
  input  logic              SPI_EN,
  input  logic              SPI_MOSI,
  output logic              SPI_MISO,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              underrun
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic sclk_rise, sclk_fall;
  logic en_rise, en_fall;
  logic mosi_s;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
    .clk(clk), .rst(rst), .d_i(SPI_CLK),
    .q_o(), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_en (
    .clk(clk), .rst(rst), .d_i(SPI_EN),
    .q_o(), .rise_o(en_rise), .fall_o(en_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mosi (
    .clk(clk), .rst(rst), .d_i(SPI_MOSI),
    .q_o(mosi_s), .rise_o(), .fall_o()
  );

  spi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              buf_full_q, buf_full_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              underrun_q, underrun_d;
  logic              miso_q, miso_d;
  logic              load_tx;
  logic [DATA_W-1:0] rx_next;

  assign rx_next = {rx_shift_q[DATA_W-2:0], mosi_s};

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    underrun_d = 1'b0;
    load_tx    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (en_rise) begin
          state_d   = ACTIVE;
          bit_cnt_d = '0;
          load_tx   = 1'b1;
        end
      end
      ACTIVE: begin
        if (sclk_rise) begin
          rx_shift_d = rx_next;
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            rx_data_d  = rx_next;
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (sclk_fall) begin
          if (bit_cnt_q != '0) tx_shift_d = tx_shift_q << 1;
          else                 load_tx    = 1'b1;
        end
        // select drop wins over a coincident reload
        if (en_fall) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          load_tx   = 1'b0;
        end
      end
      default: ;
    endcase

    if (load_tx) begin
      if (buf_full_q) begin
        tx_shift_d = buf_q;
        buf_full_d = 1'b0;
      end else begin
        tx_shift_d = '0;
        underrun_d = 1'b1;
      end
    end

    if (tx_valid && !buf_full_q) begin
      buf_d      = tx_data;
      buf_full_d = 1'b1;
    end

    miso_d = (state_d == ACTIVE) ? tx_shift_d[DATA_W-1] : 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      miso_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      underrun_q <= underrun_d;
      miso_q     <= miso_d;
    end
  end

  assign SPI_MISO = miso_q;
  assign tx_ready = ~buf_full_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = (state_q == ACTIVE);
  assign underrun = underrun_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral acting as a mode-0 SPI master.
module tb_spi_peripheral;

  localparam int HP = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       SPI_CLK = 1'b0;
  logic       SPI_EN = 1'b0;
  logic       SPI_MOSI = 1'b0;
  logic       SPI_MISO;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       underrun;

  int total = 0;
  int bad = 0;

  int         rx_cnt = 0;
  int         ur_cnt = 0;
  logic [7:0] rx_log [16];

  always #5 clk = ~clk;

  spi_peripheral #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .SPI_CLK(SPI_CLK), .SPI_EN(SPI_EN),
    .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .underrun(underrun)
  );

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_log[rx_cnt % 16] <= rx_data;
      rx_cnt <= rx_cnt + 1;
    end
    if (underrun) ur_cnt <= ur_cnt + 1;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic en_up();
    @(negedge clk);
    SPI_EN = 1'b1;
  endtask

  task automatic shift_words(input int nbits,
                             input logic [15:0] mosi,
                             input bit drop,
                             output logic [15:0] miso);
    miso = '0;
    for (int i = 0; i < nbits; i++) begin
      SPI_MOSI = mosi[nbits-1-i];
      repeat (HP) @(negedge clk);
      miso = {miso[14:0], SPI_MISO};
      SPI_CLK = 1'b1;
      repeat (HP) @(negedge clk);
      SPI_CLK = 1'b0;
      if (drop && i == nbits - 1) SPI_EN = 1'b0;
    end
  endtask

  logic [15:0] miso_w;
  int          rx0, ur0;

  initial begin
    // reset values
    repeat (3) @(negedge clk);
    check("rst_miso", 32'(SPI_MISO), 32'h0);
    check("rst_ready", 32'(tx_ready), 32'h1);
    check("rst_rxdata", 32'(rx_data), 32'h0);
    check("rst_rxvalid", 32'(rx_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_underrun", 32'(underrun), 32'h0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // single word
    push(8'hA5);
    check("single_full", 32'(tx_ready), 32'h0);
    rx0 = rx_cnt; ur0 = ur_cnt;
    en_up();
    repeat (3) @(negedge clk);
    check("single_busy", 32'(busy), 32'h1);
    check("single_ready", 32'(tx_ready), 32'h1);
    check("single_bit0", 32'(SPI_MISO), 32'h1);
    shift_words(8, 16'h003C, 1'b1, miso_w);
    repeat (10) @(negedge clk);
    check("single_miso", 32'(miso_w[7:0]), 32'hA5);
    check("single_rx", 32'(rx_data), 32'h3C);
    check("single_rxcnt", 32'(rx_cnt - rx0), 32'h1);
    check("single_ur", 32'(ur_cnt - ur0), 32'h0);
    check("single_idle", 32'(busy), 32'h0);

    // back-to-back
    push(8'h81);
    rx0 = rx_cnt; ur0 = ur_cnt;
    en_up();
    fork
      shift_words(16, 16'h1234, 1'b1, miso_w);
      begin
        repeat (40) @(negedge clk);
        push(8'h7E);
      end
    join
    repeat (10) @(negedge clk);
    check("b2b_miso", 32'(miso_w), 32'h817E);
    check("b2b_rxcnt", 32'(rx_cnt - rx0), 32'h2);
    check("b2b_rx0", 32'(rx_log[rx0 % 16]), 32'h12);
    check("b2b_rx1", 32'(rx_log[(rx0 + 1) % 16]), 32'h34);
    check("b2b_ur", 32'(ur_cnt - ur0), 32'h0);

    // underrun
    rx0 = rx_cnt; ur0 = ur_cnt;
    en_up();
    shift_words(8, 16'h005A, 1'b1, miso_w);
    repeat (10) @(negedge clk);
    check("ur_miso", 32'(miso_w[7:0]), 32'h00);
    check("ur_rx", 32'(rx_data), 32'h5A);
    check("ur_rxcnt", 32'(rx_cnt - rx0), 32'h1);
    check("ur_cnt", 32'(ur_cnt - ur0), 32'h1);

    // aborted frame
    rx0 = rx_cnt;
    en_up();
    shift_words(5, 16'h0015, 1'b1, miso_w);
    @(posedge clk); @(posedge clk); #1;
    check("abort_busy_hold", 32'(busy), 32'h1);
    @(posedge clk); #1;
    check("abort_busy_fall", 32'(busy), 32'h0);
    repeat (10) @(negedge clk);
    check("abort_rxcnt", 32'(rx_cnt - rx0), 32'h0);
    check("abort_rx", 32'(rx_data), 32'h5A);

    // handshake coincident with load of an empty buffer
    rx0 = rx_cnt; ur0 = ur_cnt;
    en_up();
    repeat (2) @(negedge clk);
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    check("coll_busy", 32'(busy), 32'h1);
    check("coll_underrun", 32'(underrun), 32'h1);
    check("coll_full", 32'(tx_ready), 32'h0);
    @(negedge clk);
    tx_valid = 1'b0;
    shift_words(16, 16'hF00F, 1'b1, miso_w);
    repeat (10) @(negedge clk);
    check("coll_miso", 32'(miso_w), 32'h00C3);
    check("coll_rxcnt", 32'(rx_cnt - rx0), 32'h2);
    check("coll_rx0", 32'(rx_log[rx0 % 16]), 32'hF0);
    check("coll_rx1", 32'(rx_log[(rx0 + 1) % 16]), 32'h0F);
    check("coll_ur", 32'(ur_cnt - ur0), 32'h1);

    // async reset mid-frame
    push(8'h55);
    en_up();
    shift_words(4, 16'h000A, 1'b0, miso_w);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("mrst_busy", 32'(busy), 32'h0);
    check("mrst_miso", 32'(SPI_MISO), 32'h0);
    check("mrst_ready", 32'(tx_ready), 32'h1);
    check("mrst_rx", 32'(rx_data), 32'h0);
    check("mrst_rxvalid", 32'(rx_valid), 32'h0);
    check("mrst_ur", 32'(underrun), 32'h0);
    SPI_EN = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rx0 = rx_cnt;
    push(8'h99);
    en_up();
    shift_words(8, 16'h0066, 1'b1, miso_w);
    repeat (10) @(negedge clk);
    check("post_miso", 32'(miso_w[7:0]), 32'h99);
    check("post_rx", 32'(rx_data), 32'h66);
    check("post_rxcnt", 32'(rx_cnt - rx0), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_peripheral.md
Name: spi_peripheral

Overview:
- SPI target (slave) endpoint; the far end of the team's SPI_driver master. Byte-oriented, mode 0 (CPOL=0, CPHA=0), MSB first.
- Oversamples SPI_CLK / SPI_EN / SPI_MOSI in the system clock domain and shifts receive data in while shifting transmit data out on SPI_MISO.
- Presents received words on a one-cycle strobe. Accepts the next transmit word through a single-entry buffer with a valid/ready handshake.

Parameters:
- DATA_W, 8, word width in bits.
- SYNC_STAGES, 2, synchronizer flops on each SPI input (minimum 2).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset.
- SPI_CLK  input  1  serial clock from master; idles low.
- SPI_EN  input  1  select from master; active-high, frames a transfer.
- SPI_MOSI  input  1  serial data from master.
- SPI_MISO  output  1  serial data to master.
- tx_data  input  DATA_W  next word to transmit.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  transmit buffer empty.
- rx_data  output  DATA_W  last complete received word.
- rx_valid  output  1  one-cycle strobe: rx_data updated.
- busy  output  1  transfer in progress (state ACTIVE).
- underrun  output  1  one-cycle strobe: a word was started with the transmit buffer empty.

Behaviour:
- Reset (rst=0, async): state IDLE, bit_cnt=0, shift registers=0, tx buffer empty.
  - Outputs: SPI_MISO=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, underrun=0.
- Synchronizers:
  - SPI inputs pass SYNC_STAGES flops. Edge detect compares the last synced value with one more flop.
  - Detect latency is SYNC_STAGES+1 clk cycles from pin to internal rise/fall event.
  - SPI_CLK high and low phases must each be >= SYNC_STAGES+2 clk cycles. Faster clocks are unsupported and are not checked.
- TX buffer:
  - tx_ready = !buf_full.
  - Handshake fires when tx_valid && tx_ready. The buffer captures tx_data and becomes full on the next edge.
  - Consuming the buffer (load into tx shift) empties it.
- State machine, states IDLE, ACTIVE:
  - IDLE -> ACTIVE on synced SPI_EN rise.
    - bit_cnt=0.
    - tx_shift loads from the buffer if full, else 0x00 and underrun pulses.
    - The first bit is presented before the first SCLK rise.
  - ACTIVE on SCLK rise: rx_shift <= {rx_shift[DATA_W-2:0], MOSI_sync}; bit_cnt++.
    - When bit_cnt reaches DATA_W: rx_data <= completed word, rx_valid=1 for exactly one cycle, bit_cnt <= 0.
  - ACTIVE on SCLK fall:
    - bit_cnt != 0: tx_shift shifts left with 0 fill.
    - bit_cnt == 0 after a completed word: tx_shift reloads from the buffer (or 0x00 plus underrun pulse). This supports back-to-back words within one SPI_EN frame.
  - ACTIVE -> IDLE on synced SPI_EN fall.
    - A partial word is discarded: no rx_valid, bit_cnt=0.
    - A word already loaded into tx_shift is lost and is not returned to the buffer.
- SPI_MISO = tx_shift[DATA_W-1] while ACTIVE, 0 in IDLE (registered).
- rx_data holds its value until the next completed word.
- Simultaneous events:
  - Handshake in the same cycle as a load attempt on an empty buffer: the load sees empty, so 0x00 is sent and underrun pulses. The new word stays in the buffer for the next word.
  - SPI_EN fall coincident with the DATA_W-th SCLK rise: the word completes and rx_valid pulses, then the state goes IDLE.
- SCLK edges while in IDLE are ignored.
- Async reset mid-transfer: immediate return to reset values, with no strobe.

Decomposition:
- Shared package spi_pkg:
  - state enum spi_state_e {IDLE, ACTIVE}.
  - default width constant SPI_DATA_W=8.
  - MSB-first / mode-0 constants shared with SPI_driver.
- Sub-module spi_sync_edge: SYNC_STAGES synchronizer plus rise/fall detect, instantiated three times (rise/fall outputs used only for SCLK and EN).

Test Plan:
- Reset mid-frame: assert rst after 4 SCLK rises -> all outputs at reset values within the same cycle; next frame starts clean, with no stale rx_valid.
- Single word: preload tx 0xA5; master sends 0x3C in mode 0 at SCLK half-period 8 clk -> MISO bits 1,0,1,0,0,1,0,1; rx_data=0x3C; exactly one rx_valid pulse; tx_ready returns 1 at EN rise.
- Back-to-back: preload 0x81, refill 0x7E while ACTIVE; master sends 0x12, 0x34 in one EN frame -> MISO 0x81 then 0x7E; rx_valid twice with 0x12 then 0x34.
- Underrun: empty buffer at EN rise -> underrun pulses once; MISO all zeros; rx_data still captured correctly.
- Aborted frame: EN drops after 5 bits -> no rx_valid; rx_data keeps its previous value; busy falls SYNC_STAGES+1 cycles after the pin.
- Handshake/load collision: tx_valid rises in the exact cycle the load occurs on an empty buffer -> 0x00 sent and underrun pulses; word sent in the following word slot.
